// File: rtl/reg_alloc_unit.sv
// ---------------------------------------------------------------------------
// reg_alloc_unit
//
// Purpose:
//   Register allocation unit placed between the thread manager / IBuffer and
//   the operand collectors. Each hardware warp's logical registers are mapped
//   onto physical register-file slots, where a slot is CHUNK adjacent banks in
//   a single row. Allocation scans the free map one slot per cycle starting at
//   a persistent scan pointer; deallocation releases every slot of a warp in a
//   single cycle. Source and writeback address translation is combinational.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   alloc_req/warp/nreg      allocation request (sampled only when alloc_ready)
//   alloc_ready              unit is idle and accepts requests
//   alloc_done, alloc_fail   one-cycle completion / rejection pulses
//   exit_req, exit_warp      free all slots held by a warp (sampled when idle)
//   free_count               number of free slots
//   rd_warp, src1/src2_reg   source operand lookup -> valid/row/bank
//   wb_warp, wb_reg          writeback lookup -> valid/row/bank
//   bank_conflict            both sources valid and in the same bank
//
// Configuration:
//   RAU_CONFLICT_DETECT_EN   when defined, bank_conflict compares the source
//                            banks; otherwise it is tied low.
// ---------------------------------------------------------------------------
module reg_alloc_unit #(
    parameter int NUM_WARPS     = 8,
    parameter int REGS_PER_WARP = 8,
    parameter int NUM_BANKS     = 4,
    parameter int NUM_ROWS      = 8,
    parameter int CHUNK         = 2,
    parameter int WW            = $clog2(NUM_WARPS),
    parameter int RW            = $clog2(REGS_PER_WARP),
    parameter int BW            = $clog2(NUM_BANKS),
    parameter int ROWW          = $clog2(NUM_ROWS),
    parameter int SW            = $clog2(NUM_ROWS * (NUM_BANKS / CHUNK))
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alloc_req,
    input  logic [WW-1:0]   alloc_warp,
    input  logic [RW:0]     alloc_nreg,
    output logic            alloc_ready,
    output logic            alloc_done,
    output logic            alloc_fail,
    input  logic            exit_req,
    input  logic [WW-1:0]   exit_warp,
    output logic [SW:0]     free_count,
    input  logic [WW-1:0]   rd_warp,
    input  logic [RW-1:0]   src1_reg,
    input  logic [RW-1:0]   src2_reg,
    output logic            src1_valid,
    output logic [ROWW-1:0] src1_row,
    output logic [BW-1:0]   src1_bank,
    output logic            src2_valid,
    output logic [ROWW-1:0] src2_row,
    output logic [BW-1:0]   src2_bank,
    input  logic [WW-1:0]   wb_warp,
    input  logic [RW-1:0]   wb_reg,
    output logic            wb_valid,
    output logic [ROWW-1:0] wb_row,
    output logic [BW-1:0]   wb_bank,
    output logic            bank_conflict
);

    localparam int GROUPS    = NUM_BANKS / CHUNK;
    localparam int NUM_SLOTS = NUM_ROWS * GROUPS;
    localparam int CPW       = REGS_PER_WARP / CHUNK;
    localparam int CW        = (CPW > 1) ? $clog2(CPW) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ALLOC,
        DEALLOC
    } state_t;

    state_t               state;
    logic [NUM_SLOTS-1:0] slot_free;
    logic [SW-1:0]        ptr;
    logic                 lut_valid [NUM_WARPS][CPW];
    logic [SW-1:0]        lut_slot  [NUM_WARPS][CPW];
    logic [WW-1:0]        cur_warp;
    logic [RW:0]          need;
    logic [CW-1:0]        k;

    logic [RW:0]          need_req;
    logic                 warp_busy;
    logic [SW:0]          exit_count;

    assign alloc_ready = (state == IDLE);

    // Request-side decode: slots needed, whether the warp already owns
    // anything, and how many slots the exiting warp gives back.
    always_comb begin
        need_req   = (RW+1)'((int'(alloc_nreg) + CHUNK - 1) / CHUNK);
        warp_busy  = 1'b0;
        exit_count = '0;
        for (int c = 0; c < CPW; c++) begin
            if (lut_valid[alloc_warp][c]) warp_busy = 1'b1;
            if (lut_valid[cur_warp][c])   exit_count = exit_count + (SW+1)'(1);
        end
    end

    // Control FSM with registered done/fail pulses. The scan pointer is not
    // rewound between allocations, so later requests continue where the
    // previous scan stopped and skip occupied slots.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            slot_free  <= '1;
            ptr        <= '0;
            free_count <= (SW+1)'(NUM_SLOTS);
            alloc_done <= 1'b0;
            alloc_fail <= 1'b0;
            cur_warp   <= '0;
            need       <= '0;
            k          <= '0;
            for (int w = 0; w < NUM_WARPS; w++) begin
                for (int c = 0; c < CPW; c++) begin
                    lut_valid[w][c] <= 1'b0;
                    lut_slot[w][c]  <= '0;
                end
            end
        end else begin
            alloc_done <= 1'b0;
            alloc_fail <= 1'b0;
            case (state)
                IDLE: begin
                    if (exit_req) begin
                        cur_warp <= exit_warp;
                        state    <= DEALLOC;
                    end else if (alloc_req) begin
                        if (int'(alloc_nreg) > REGS_PER_WARP ||
                            int'(need_req) > int'(free_count) || warp_busy) begin
                            alloc_fail <= 1'b1;
                        end else if (alloc_nreg == '0) begin
                            alloc_done <= 1'b1;
                        end else begin
                            cur_warp <= alloc_warp;
                            need     <= need_req;
                            k        <= '0;
                            state    <= ALLOC;
                        end
                    end
                end
                ALLOC: begin
                    ptr <= (int'(ptr) == NUM_SLOTS - 1) ? '0 : ptr + SW'(1);
                    if (slot_free[ptr]) begin
                        slot_free[ptr]          <= 1'b0;
                        lut_valid[cur_warp][k]  <= 1'b1;
                        lut_slot[cur_warp][k]   <= ptr;
                        k                       <= k + CW'(1);
                        free_count              <= free_count - (SW+1)'(1);
                        if (int'(k) + 1 == int'(need)) begin
                            alloc_done <= 1'b1;
                            state      <= IDLE;
                        end
                    end
                end
                DEALLOC: begin
                    for (int c = 0; c < CPW; c++) begin
                        if (lut_valid[cur_warp][c]) begin
                            lut_valid[cur_warp][c]            <= 1'b0;
                            slot_free[lut_slot[cur_warp][c]]  <= 1'b1;
                        end
                    end
                    free_count <= free_count + exit_count;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Translation: chunk index selects the table entry, the slot number gives
    // row and bank group, and the register's position inside the chunk picks
    // the bank within the group.
    function automatic logic [ROWW+BW:0] xlate(input logic [WW-1:0] w,
                                               input logic [RW-1:0] r);
        logic [CW-1:0] ci;
        int            s;
        ci = CW'(int'(r) / CHUNK);
        s  = int'(lut_slot[w][ci]);
        return {lut_valid[w][ci], ROWW'(s / GROUPS),
                BW'((s % GROUPS) * CHUNK + int'(r) % CHUNK)};
    endfunction

    always_comb begin
        {src1_valid, src1_row, src1_bank} = xlate(rd_warp, src1_reg);
        {src2_valid, src2_row, src2_bank} = xlate(rd_warp, src2_reg);
        {wb_valid, wb_row, wb_bank}       = xlate(wb_warp, wb_reg);
    end

`ifdef RAU_CONFLICT_DETECT_EN
    assign bank_conflict = src1_valid & src2_valid & (src1_bank == src2_bank);
`else
    assign bank_conflict = 1'b0;
`endif

endmodule

// File: tb/tb_reg_alloc_unit.sv
// ---------------------------------------------------------------------------
// tb_reg_alloc_unit
//
// Purpose:
//   Self-checking bench for reg_alloc_unit. Directed scenarios followed by a
//   randomized sequence of allocate / exit requests, all compared against a
//   behavioural model that keeps a per-warp list of owned slots, a free-slot
//   array and a scan pointer. Honors RAU_CONFLICT_DETECT_EN for the expected
//   bank_conflict value.
// ---------------------------------------------------------------------------
module tb_reg_alloc_unit;

    localparam int NUM_WARPS     = 8;
    localparam int REGS_PER_WARP = 8;
    localparam int NUM_BANKS     = 4;
    localparam int NUM_ROWS      = 8;
    localparam int CHUNK         = 2;
    localparam int GROUPS        = NUM_BANKS / CHUNK;
    localparam int NUM_SLOTS     = NUM_ROWS * GROUPS;
    localparam int CPW           = REGS_PER_WARP / CHUNK;
    localparam int WW            = $clog2(NUM_WARPS);
    localparam int RW            = $clog2(REGS_PER_WARP);
    localparam int BW            = $clog2(NUM_BANKS);
    localparam int ROWW          = $clog2(NUM_ROWS);
    localparam int SW            = $clog2(NUM_SLOTS);

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            alloc_req = 1'b0;
    logic [WW-1:0]   alloc_warp = '0;
    logic [RW:0]     alloc_nreg = '0;
    logic            alloc_ready;
    logic            alloc_done;
    logic            alloc_fail;
    logic            exit_req = 1'b0;
    logic [WW-1:0]   exit_warp = '0;
    logic [SW:0]     free_count;
    logic [WW-1:0]   rd_warp = '0;
    logic [RW-1:0]   src1_reg = '0;
    logic [RW-1:0]   src2_reg = '0;
    logic            src1_valid, src2_valid, wb_valid;
    logic [ROWW-1:0] src1_row, src2_row, wb_row;
    logic [BW-1:0]   src1_bank, src2_bank, wb_bank;
    logic [WW-1:0]   wb_warp = '0;
    logic [RW-1:0]   wb_reg = '0;
    logic            bank_conflict;

    reg_alloc_unit dut (
        .clk(clk), .rst(rst),
        .alloc_req(alloc_req), .alloc_warp(alloc_warp), .alloc_nreg(alloc_nreg),
        .alloc_ready(alloc_ready), .alloc_done(alloc_done), .alloc_fail(alloc_fail),
        .exit_req(exit_req), .exit_warp(exit_warp), .free_count(free_count),
        .rd_warp(rd_warp), .src1_reg(src1_reg), .src2_reg(src2_reg),
        .src1_valid(src1_valid), .src1_row(src1_row), .src1_bank(src1_bank),
        .src2_valid(src2_valid), .src2_row(src2_row), .src2_bank(src2_bank),
        .wb_warp(wb_warp), .wb_reg(wb_reg),
        .wb_valid(wb_valid), .wb_row(wb_row), .wb_bank(wb_bank),
        .bank_conflict(bank_conflict)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: slot owned by each (warp, chunk), -1 when unmapped.
    int m_slot [NUM_WARPS][CPW];
    bit m_free [NUM_SLOTS];
    int m_ptr;

    task automatic check_output(input string tag, input logic [31:0] obs,
                                input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int w = 0; w < NUM_WARPS; w++)
            for (int c = 0; c < CPW; c++) m_slot[w][c] = -1;
        for (int s = 0; s < NUM_SLOTS; s++) m_free[s] = 1'b1;
        m_ptr = 0;
    endtask

    function automatic int model_free_count();
        int n = 0;
        for (int s = 0; s < NUM_SLOTS; s++) if (m_free[s]) n++;
        return n;
    endfunction

    function automatic bit model_owns(input int w);
        for (int c = 0; c < CPW; c++) if (m_slot[w][c] >= 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_lookup(input int w, input int r, output bit v,
                                output int row, output int bank);
        int s = m_slot[w][r / CHUNK];
        v    = (s >= 0);
        row  = v ? s / GROUPS : 0;
        bank = v ? (s % GROUPS) * CHUNK + r % CHUNK : 0;
    endtask

    // Drives lookup inputs and compares the three translations plus conflict.
    task automatic check_lookup(input int w, input int r1, input int r2,
                                input int ww, input int wr);
        bit v1, v2, vw, conf;
        int row1, bank1, row2, bank2, roww, bankw;
        rd_warp  = WW'(w);
        src1_reg = RW'(r1);
        src2_reg = RW'(r2);
        wb_warp  = WW'(ww);
        wb_reg   = RW'(wr);
        #1;
        model_lookup(w, r1, v1, row1, bank1);
        model_lookup(w, r2, v2, row2, bank2);
        model_lookup(ww, wr, vw, roww, bankw);
        check_output("src1_valid", 32'(src1_valid), 32'(v1));
        if (v1) begin
            check_output("src1_row", 32'(src1_row), 32'(row1));
            check_output("src1_bank", 32'(src1_bank), 32'(bank1));
        end
        check_output("src2_valid", 32'(src2_valid), 32'(v2));
        if (v2) begin
            check_output("src2_row", 32'(src2_row), 32'(row2));
            check_output("src2_bank", 32'(src2_bank), 32'(bank2));
        end
        check_output("wb_valid", 32'(wb_valid), 32'(vw));
        if (vw) begin
            check_output("wb_row", 32'(wb_row), 32'(roww));
            check_output("wb_bank", 32'(wb_bank), 32'(bankw));
        end
`ifdef RAU_CONFLICT_DETECT_EN
        conf = v1 && v2 && (bank1 == bank2);
`else
        conf = 1'b0;
`endif
        check_output("bank_conflict", 32'(bank_conflict), 32'(conf));
    endtask

    // Issues one allocation request and follows it to completion.
    task automatic apply_stimulus(input int w, input int n);
        int  need, exp_cycles, got_cycles, k;
        bit  fail;
        need = (n + CHUNK - 1) / CHUNK;
        fail = (n > REGS_PER_WARP) || (need > model_free_count()) || model_owns(w);
        alloc_req  = 1'b1;
        alloc_warp = WW'(w);
        alloc_nreg = (RW+1)'(n);
        tick();
        alloc_req = 1'b0;
        if (fail) begin
            check_output("fail_pulse", 32'(alloc_fail), 32'd1);
            check_output("fail_no_done", 32'(alloc_done), 32'd0);
            check_output("fail_ready", 32'(alloc_ready), 32'd1);
        end else if (n == 0) begin
            check_output("zero_done", 32'(alloc_done), 32'd1);
            check_output("zero_no_fail", 32'(alloc_fail), 32'd0);
        end else begin
            check_output("alloc_busy", 32'(alloc_ready), 32'd0);
            exp_cycles = 0;
            k = 0;
            while (k < need) begin
                if (m_free[m_ptr]) begin
                    m_free[m_ptr] = 1'b0;
                    m_slot[w][k]  = m_ptr;
                    k++;
                end
                m_ptr = (m_ptr + 1) % NUM_SLOTS;
                exp_cycles++;
            end
            got_cycles = 0;
            while (alloc_done !== 1'b1 && got_cycles < 4 * NUM_SLOTS) begin
                tick();
                got_cycles++;
            end
            check_output("alloc_done_seen", 32'(alloc_done), 32'd1);
            check_output("alloc_cycles", 32'(got_cycles), 32'(exp_cycles));
            check_output("alloc_ready_after", 32'(alloc_ready), 32'd1);
        end
        check_output("free_count", 32'(free_count), 32'(model_free_count()));
    endtask

    task automatic model_exit(input int w);
        for (int c = 0; c < CPW; c++) begin
            if (m_slot[w][c] >= 0) begin
                m_free[m_slot[w][c]] = 1'b1;
                m_slot[w][c] = -1;
            end
        end
    endtask

    task automatic apply_exit(input int w);
        exit_req  = 1'b1;
        exit_warp = WW'(w);
        tick();
        exit_req = 1'b0;
        check_output("dealloc_busy", 32'(alloc_ready), 32'd0);
        tick();
        model_exit(w);
        check_output("dealloc_ready", 32'(alloc_ready), 32'd1);
        check_output("dealloc_free", 32'(free_count), 32'(model_free_count()));
    endtask

    task automatic random_lookups(input int n);
        for (int i = 0; i < n; i++)
            check_lookup($urandom_range(0, NUM_WARPS - 1), $urandom_range(0, REGS_PER_WARP - 1),
                         $urandom_range(0, REGS_PER_WARP - 1), $urandom_range(0, NUM_WARPS - 1),
                         $urandom_range(0, REGS_PER_WARP - 1));
    endtask

    initial begin
        model_reset();

        // Reset state
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        check_output("rst_free", 32'(free_count), 32'(NUM_SLOTS));
        check_output("rst_ready", 32'(alloc_ready), 32'd1);
        check_output("rst_done", 32'(alloc_done), 32'd0);
        check_output("rst_fail", 32'(alloc_fail), 32'd0);
        check_lookup(0, 5, 0, 7, 7);

        // Scenario 1: full warp allocation from an empty map
        apply_stimulus(0, 8);
        check_output("s1_free", 32'(free_count), 32'd12);
        check_lookup(0, 5, 4, 0, 5);
        check_output("s1_w0r5_row", 32'(src1_row), 32'd1);
        check_output("s1_w0r5_bank", 32'(src1_bank), 32'd1);

        // Bank conflict: r1 and r5 both land in bank 1, r4 in bank 0
        check_lookup(0, 1, 5, 0, 1);
`ifdef RAU_CONFLICT_DETECT_EN
        check_output("conflict_same", 32'(bank_conflict), 32'd1);
`else
        check_output("conflict_off", 32'(bank_conflict), 32'd0);
`endif
        check_lookup(0, 1, 4, 0, 1);
        check_output("conflict_diff", 32'(bank_conflict), 32'd0);

        // Scenario 2: exhaust the map, then an over-subscribed request
        apply_stimulus(1, 8);
        apply_stimulus(2, 8);
        apply_stimulus(3, 8);
        check_output("s2_full", 32'(free_count), 32'd0);
        apply_stimulus(4, 2);
        check_output("s2_idle", 32'(alloc_ready), 32'd1);

        // Scenario 3: free w1 and reuse its slots after skipping 0-3
        apply_exit(1);
        check_output("s3_free", 32'(free_count), 32'd4);
        apply_stimulus(4, 3);
        check_lookup(4, 2, 0, 4, 2);
        check_output("s3_w4r2_row", 32'(wb_row), 32'd2);
        check_output("s3_w4r2_bank", 32'(wb_bank), 32'd2);

        // Re-allocating a warp that already owns slots is rejected
        apply_stimulus(4, 2);

        // Scenario 4: exit and alloc together; exit wins, alloc retried
        exit_req   = 1'b1;
        exit_warp  = WW'(0);
        alloc_req  = 1'b1;
        alloc_warp = WW'(5);
        alloc_nreg = (RW+1)'(4);
        tick();
        exit_req = 1'b0;
        check_output("s4_dealloc_busy", 32'(alloc_ready), 32'd0);
        check_output("s4_no_done", 32'(alloc_done), 32'd0);
        tick();
        alloc_req = 1'b0;
        model_exit(0);
        check_output("s4_ready", 32'(alloc_ready), 32'd1);
        check_output("s4_free", 32'(free_count), 32'(model_free_count()));
        apply_stimulus(5, 4);
        apply_stimulus(6, 0);

        // Scenario 5: reset in the middle of an allocation
        rst = 1'b0;
        tick();
        rst = 1'b1;
        model_reset();
        alloc_req  = 1'b1;
        alloc_warp = WW'(0);
        alloc_nreg = (RW+1)'(8);
        tick();
        alloc_req = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_output("s5_free", 32'(free_count), 32'(NUM_SLOTS));
        check_output("s5_no_done", 32'(alloc_done), 32'd0);
        check_output("s5_ready", 32'(alloc_ready), 32'd1);
        for (int r = 0; r < REGS_PER_WARP; r++) check_lookup(0, r, r, 0, r);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_output("s5_quiet_done", 32'(alloc_done), 32'd0);
        end

        // Randomized allocate / exit traffic
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) == 0)
                apply_exit($urandom_range(0, NUM_WARPS - 1));
            else
                apply_stimulus($urandom_range(0, NUM_WARPS - 1), $urandom_range(0, 9));
            random_lookups(3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
